// File: rtl/harmonic_mixer_if.sv
// Sample stream bundle between the harmonic generators, the mixer and the sink.
// Handshake: in_valid and out_valid are single-cycle qualifiers with no ready;
// the mixer accepts a sample on every edge where in_valid=1 and the sink must
// take out_sample on every cycle where out_valid=1.
interface harmonic_mixer_if #(
    parameter int WIDTH = 16
);
    logic [1:0]              weight;
    logic                    in_valid;
    logic signed [WIDTH-1:0] fund_sample;
    logic signed [WIDTH-1:0] harm2_sample;
    logic signed [WIDTH-1:0] harm3_sample;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_sample;

    // Producer side: drives samples and weight, observes the mixed result.
    modport master (
        output weight, in_valid, fund_sample, harm2_sample, harm3_sample,
        input  out_valid, out_sample
    );

    // Mixer side: consumes samples and weight, produces the mixed result.
    modport slave (
        input  weight, in_valid, fund_sample, harm2_sample, harm3_sample,
        output out_valid, out_sample
    );
endinterface

// File: rtl/harmonic_mixer.sv
// Three-stage harmonic mixer: capture, weighted sum, saturate.
// Each sample carries the weight captured alongside it, so weight changes
// never affect samples already in flight. All outputs come from registers.
module harmonic_mixer #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    harmonic_mixer_if.slave   bus
);
    localparam int SW = WIDTH + 2;

    // Saturation bounds expressed in the widened sum domain.
    localparam logic signed [SW-1:0] max_pos = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] min_neg = {3'b111, {(WIDTH-1){1'b0}}};

    // Stage 1 registers
    logic                    valid1;
    logic [1:0]              weight1;
    logic signed [WIDTH-1:0] fund1;
    logic signed [WIDTH-1:0] harm2_1;
    logic signed [WIDTH-1:0] harm3_1;

    // Stage 2 registers
    logic                    valid2;
    logic signed [SW-1:0]    sum2;

    // Stage 3 registers
    logic                    valid3;
    logic signed [WIDTH-1:0] sample3;

    // Combinational terms for stage 2
    logic signed [SW-1:0]    f_ext;
    logic signed [SW-1:0]    h2_ext;
    logic signed [SW-1:0]    h3_ext;
    logic signed [SW-1:0]    sum_next;
    logic signed [WIDTH-1:0] sat_next;

    // Stage 1: capture samples with their weight; data holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1  <= 1'b0;
            weight1 <= 2'b00;
            fund1   <= '0;
            harm2_1 <= '0;
            harm3_1 <= '0;
        end else begin
            valid1 <= bus.in_valid;
            if (bus.in_valid) begin
                weight1 <= bus.weight;
                fund1   <= bus.fund_sample;
                harm2_1 <= bus.harm2_sample;
                harm3_1 <= bus.harm3_sample;
            end
        end
    end

    // Stage 2 datapath: sign-extend, floor-shift and sum by profile.
    always_comb begin
        f_ext  = {{2{fund1[WIDTH-1]}}, fund1};
        h2_ext = {{2{harm2_1[WIDTH-1]}}, harm2_1};
        h3_ext = {{2{harm3_1[WIDTH-1]}}, harm3_1};
        sum_next = f_ext;
        case (weight1)
            2'b01:   sum_next = (f_ext >>> 1) + (h2_ext >>> 2) + (h3_ext >>> 2);
            2'b10:   sum_next = f_ext + (h2_ext >>> 1) + (h3_ext >>> 1);
            default: sum_next = f_ext;   // 00 and the illegal 11 both pass f
        endcase
    end

    // Stage 2 register: weighted sum and its valid tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid2 <= 1'b0;
            sum2   <= '0;
        end else begin
            valid2 <= valid1;
            sum2   <= sum_next;
        end
    end

    // Stage 3 datapath: clamp the widened sum to the output range.
    always_comb begin
        sat_next = sum2[WIDTH-1:0];
        if (sum2 > max_pos) begin
            sat_next = max_pos[WIDTH-1:0];
        end else if (sum2 < min_neg) begin
            sat_next = min_neg[WIDTH-1:0];
        end
    end

    // Stage 3 register: output only updates on a valid sample, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid3  <= 1'b0;
            sample3 <= '0;
        end else begin
            valid3 <= valid2;
            if (valid2) begin
                sample3 <= sat_next;
            end
        end
    end

    assign bus.out_valid  = valid3;
    assign bus.out_sample = sample3;
endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed testbench for harmonic_mixer with hand-computed expected values.
module tb_harmonic_mixer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_q[$];

    harmonic_mixer_if #(.WIDTH(W)) bus ();

    harmonic_mixer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.weight       = 2'b00;
        bus.fund_sample  = '0;
        bus.harm2_sample = '0;
        bus.harm3_sample = '0;
    endtask

    task automatic set_sample(input int w, input int f, input int h2, input int h3);
        bus.weight       = 2'(w);
        bus.fund_sample  = W'(f);
        bus.harm2_sample = W'(h2);
        bus.harm3_sample = W'(h3);
        bus.in_valid     = 1'b1;
    endtask

    // Send one sample (called #1 after a rising edge) and check latency,
    // the result, the single-cycle pulse and the hold afterwards.
    task automatic run_one(input string tag, input int w, input int f,
                           input int h2, input int h3, input int exp);
        set_sample(w, f, h2, h3);
        @(posedge clk);                       // edge N: captured
        #1;
        bus.in_valid     = 1'b0;
        bus.weight       = 2'(w) ^ 2'b11;     // in-flight sample must ignore this
        bus.fund_sample  = W'(-7);
        bus.harm2_sample = W'(-7);
        bus.harm3_sample = W'(-7);
        @(negedge clk);
        check({tag, "_lat0"}, int'(bus.out_valid), 0);
        @(posedge clk);                       // edge N+1
        @(negedge clk);
        check({tag, "_lat1"}, int'(bus.out_valid), 0);
        @(posedge clk);                       // edge N+2
        @(negedge clk);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_sample"}, int'(bus.out_sample), exp);
        @(posedge clk);                       // edge N+3
        @(negedge clk);
        check({tag, "_pulse"}, int'(bus.out_valid), 0);
        check({tag, "_hold"}, int'(bus.out_sample), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset block
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_sample", int'(bus.out_sample), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Profile 00 and illegal 11
        run_one("p00",      0, 1000, 500, -200, 1000);
        run_one("p11",      3, 1000, 500, -200, 1000);

        // Profile 01 arithmetic and floor shifting
        run_one("p01_neg3", 1, -3, 0, 0, -2);
        run_one("p01_neg1", 1, -1, -1, -1, -3);
        run_one("p10_pos",  2, 30000, 10000, 10000, 32767);
        run_one("p10_neg",  2, -30000, -10000, -10000, -32768);
        run_one("p10_mid",  2, 100, 20, -40, 90);
        run_one("p10_edge", 2, 32767, 0, 1, 32767);
        run_one("p01_mix",  1, 1000, 400, -400, 500);

        // Idle hold after the 500 result
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", int'(bus.out_valid), 0);
            check("idle_sample", int'(bus.out_sample), 500);
            @(posedge clk);
            #1;
        end

        // Back-to-back with weight changing every cycle
        exp_q = '{1000, 500, 1000};
        for (int i = 0; i < 3; i++) begin
            set_sample(i, 1000, 0, 0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_valid", int'(bus.out_valid), 1);
            check("b2b_sample", int'(bus.out_sample), exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("b2b_end", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;

        // Reset flush: sample at edge N, reset at N+1 with a colliding sample
        set_sample(0, 1234, 0, 0);
        @(posedge clk);                       // edge N
        #1;
        reset = 1'b1;
        set_sample(2, 777, 0, 0);             // discarded: reset wins
        @(posedge clk);                       // edge N+1
        #1;
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin     // negedges after N+1 .. N+5
            @(negedge clk);
            check("flush_valid", int'(bus.out_valid), 0);
            check("flush_sample", int'(bus.out_sample), 0);
            @(posedge clk);
            #1;
        end

        // Normal operation resumes after reset
        run_one("post_rst", 0, 321, 0, 0, 321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/harmonic_mixer.md
Name: harmonic_mixer

Overview:
- Downstream consumer of the 2-bit harmonic weight selector.
- Per sample, combines the fundamental, 2nd-harmonic and 3rd-harmonic signed samples into one output sample, using the coefficient profile selected by weight.
- Fixed 3-stage registered pipeline with valid tagging; saturating output.
- Sits between the note/harmonic sample generators and the codec/sample sink.

Parameters:
WIDTH, 16, bit width of every input sample and of out_sample (two's complement).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
weight  input  2  profile select from the weight stage: 00 default, 01 WEIGHT1, 10 WEIGHT2, 11 illegal.
in_valid  input  1  one-cycle qualifier; the three sample inputs are valid this cycle.
fund_sample  input  WIDTH  signed fundamental sample.
harm2_sample  input  WIDTH  signed 2nd-harmonic sample.
harm3_sample  input  WIDTH  signed 3rd-harmonic sample.
out_valid  output  1  one-cycle qualifier for out_sample.
out_sample  output  WIDTH  signed mixed, saturated sample.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - Reset clears every pipeline register: out_valid=0, out_sample=0, internal valid bits=0, captured weight=00.
- Stage 1 (capture):
  - On the edge where in_valid=1, register the three samples and the current weight together, and set valid1=1.
  - If in_valid=0, valid1<=0 and the data registers hold their values.
- Weight binding:
  - Each sample uses the weight captured with it.
  - A weight change while samples are in flight never alters those samples.
  - weight=11 is treated as 00.
- Stage 2 (weight and sum):
  - Each term is sign-extended to WIDTH+2 bits.
  - All shifts are arithmetic right shifts, i.e. truncation toward minus infinity.
  - Profile 00: sum = f.
  - Profile 01: sum = (f>>>1) + (h2>>>2) + (h3>>>2).
  - Profile 10: sum = f + (h2>>>1) + (h3>>>1).
  - Register sum and set valid2<=valid1.
- Stage 3 (saturate):
  - If sum > 2^(WIDTH-1)-1, out_sample = 2^(WIDTH-1)-1.
  - If sum < -2^(WIDTH-1), out_sample = -2^(WIDTH-1).
  - Otherwise out_sample = sum[WIDTH-1:0].
  - out_valid<=valid2.
- Latency and throughput:
  - Exactly 3 cycles: an in_valid sampled at edge N gives out_valid=1 in the cycle following edge N+2.
  - One sample per cycle; back-to-back in_valid is supported with no bubbles.
  - No backpressure; the sink always accepts.
- Output hold: when out_valid=0, out_sample holds its last value (0 after reset).
- Reset mid-operation: reset asserted on any edge flushes all in-flight samples. No out_valid is produced for samples accepted before or during the reset cycle.
- in_valid coinciding with reset: the sample is discarded; reset wins.
- No combinational path from any input to any output.

Test Plan:
- Profile 00 passthrough: weight=00, f=1000, h2=500, h3=-200, in_valid pulse -> 3 cycles later out_valid=1 for one cycle, out_sample=1000; weight=11 with the same stimulus -> 1000.
- Profile 01 arithmetic: f=1000, h2=400, h3=-400 -> 500. Rounding check: f=-3, h2=0, h3=0 -> -2 (arithmetic shift, not -1).
- Profile 10 saturation: f=30000, h2=10000, h3=10000 -> 32767. Then f=-30000, h2=-10000, h3=-10000 -> -32768. Then f=100, h2=20, h3=-40 -> 90.
- Weight binding, back-to-back: three consecutive in_valid cycles of f=1000, h2=h3=0, with weight 00, 01, 10 respectively (weight changing every cycle) -> out_valid high 3 consecutive cycles, outputs 1000, 500, 1000.
- Reset flush: in_valid at edge N, reset=1 at edge N+1 -> out_valid stays 0 through N+5 and out_sample=0. A new sample after reset deasserts emerges normally with 3-cycle latency.
- Idle hold: after output 500, hold in_valid=0 for 10 cycles -> out_valid=0 and out_sample remains 500.
